// File: rtl/mealy_arb_pkg.sv
// Shared types and constants for the mealy_share_arb block.
//   arb_state_e : arbiter sequencer state encoding
//   rsp_t       : one response sample (b1, b2) taken from the shared cell
//   LEN_W_DEF   : default width of per-transaction bit-count fields
//   STATS_W     : width of the optional completion counters
package mealy_arb_pkg;

  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned STATS_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic b1;
    logic b2;
  } rsp_t;

endpackage

// File: rtl/mealy_share_arb_if.sv
// Requester and cell-side signal bundle of mealy_share_arb.
//   slave  : the arbiter's view (takes req/len/din/cell outputs, drives the rest)
//   master : the environment's view (requesters plus the shared cell)
// Requester side: req, len0, len1, din0, din1, gnt, busy, rsp_valid, rsp_b1,
//                 rsp_b2, done, aborted.
// Cell side:      cell_S, cell_I, cell_T, cell_rst_n, cell_b1, cell_b2.
interface mealy_share_arb_if
  import mealy_arb_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) ();

  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             din0;
  logic             din1;
  logic [1:0]       gnt;
  logic             busy;
  logic             cell_S;
  logic             cell_I;
  logic             cell_T;
  logic             cell_rst_n;
  logic             cell_b1;
  logic             cell_b2;
  logic             rsp_valid;
  logic             rsp_b1;
  logic             rsp_b2;
  logic [1:0]       done;
  logic             aborted;

  modport slave (
    input  req, len0, len1, din0, din1, cell_b1, cell_b2,
    output gnt, busy, cell_S, cell_I, cell_T, cell_rst_n,
           rsp_valid, rsp_b1, rsp_b2, done, aborted
  );

  modport master (
    output req, len0, len1, din0, din1, cell_b1, cell_b2,
    input  gnt, busy, cell_S, cell_I, cell_T, cell_rst_n,
           rsp_valid, rsp_b1, rsp_b2, done, aborted
  );

endinterface

// File: rtl/mealy_share_arb_rr_pick2.sv
// Two-way round-robin pick, purely combinational.
//   req  : request vector
//   ptr  : tie-break pointer (0 favours requester 0, 1 favours requester 1)
//   pick : one-hot winner, zero when nobody requests
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = ptr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/mealy_share_arb.sv
// Round-robin arbiter/sequencer sharing one Mealy cell between two serial
// requesters: clears the cell, streams the granted requester's bits into I
// for the latched bit count, and returns b1/b2 one cycle after each bit.
//   Clk, reset : clock, asynchronous active-low reset
//   bus        : mealy_share_arb_if.slave (requester and cell signals)
//   cnt0, cnt1 : completed non-aborted transaction counters, saturating;
//                present only when MEALY_SHARE_ARB_STATS_EN is defined
module mealy_share_arb
  import mealy_arb_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic                  Clk,
  input  logic                  reset,
  mealy_share_arb_if.slave      bus
`ifdef MEALY_SHARE_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]    cnt0,
  output logic [STATS_W-1:0]    cnt1
`endif
);

  arb_state_e       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             cell_s_q, cell_s_d;
  logic             cell_t_q, cell_t_d;
  logic             cell_rst_n_q, cell_rst_n_d;
  logic             rsp_valid_q, rsp_valid_d;
  rsp_t             rsp_q, rsp_d;
  logic [1:0]       done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [1:0]       pick;
  logic             req_lost;
  logic             cell_i;

  rr_pick2 u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick)
  );

  // The granted requester has withdrawn its request.
  assign req_lost = ~|(bus.req & gnt_q);

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rem_d       = rem_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    aborted_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = CLEAR;
          gnt_d   = pick;
          rem_d   = pick[1] ? bus.len1 : bus.len0;
          ptr_d   = pick[0];  // favour the loser next time
        end
      end
      CLEAR: begin
        if (req_lost) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d       = rem_q - LEN_W'(1);
        rsp_valid_d = 1'b1;
        rsp_d.b1    = bus.cell_b1;
        rsp_d.b2    = bus.cell_b2;
        // A drop on the last bit still counts as a full transaction.
        if (rem_q == LEN_W'(1)) begin
          state_d = DONE;
        end else if (req_lost) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    done_d       = (state_d == DONE) ? gnt_q : 2'b00;
    busy_d       = (state_d != IDLE);
    cell_s_d     = (state_d != RUN);
    cell_t_d     = (state_d == RUN);
    cell_rst_n_d = (state_d != CLEAR);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      rem_q        <= '0;
      ptr_q        <= 1'b0;
      busy_q       <= 1'b0;
      cell_s_q     <= 1'b1;
      cell_t_q     <= 1'b0;
      cell_rst_n_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_q        <= '0;
      done_q       <= 2'b00;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rem_q        <= rem_d;
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      cell_s_q     <= cell_s_d;
      cell_t_q     <= cell_t_d;
      cell_rst_n_q <= cell_rst_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_q        <= rsp_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  // Data into the cell is routed combinationally so the bit lands in the
  // same cycle the requester presents it; only the granted din is ever used.
  always_comb begin
    cell_i = 1'b0;
    if (state_q == RUN) begin
      cell_i = gnt_q[1] ? bus.din1 : (gnt_q[0] ? bus.din0 : 1'b0);
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.cell_S     = cell_s_q;
  assign bus.cell_I     = cell_i;
  assign bus.cell_T     = cell_t_q;
  assign bus.cell_rst_n = cell_rst_n_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_b1     = rsp_q.b1;
  assign bus.rsp_b2     = rsp_q.b2;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;

`ifdef MEALY_SHARE_ARB_STATS_EN
  logic [STATS_W-1:0] cnt0_q, cnt0_d;
  logic [STATS_W-1:0] cnt1_q, cnt1_d;

  // Count full completions, saturating at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if ((state_q == DONE) && !aborted_q) begin
      if (gnt_q[0] && (cnt0_q != '1)) cnt0_d = cnt0_q + STATS_W'(1);
      if (gnt_q[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + STATS_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: doc/mealy_share_arb.md
Name: mealy_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one Mealy cell datapath between two serial requesters.
- The cell is the nand → dff → tff → dual-mux path, with inputs S, I, T, its own reset, and outputs b1, b2.
- The block owns the cell's control inputs: it clears the cell before each transaction, steers the granted requester's bit stream into I for a programmed number of cycles, and returns b1/b2 per bit.
- Sits between the requester logic and the single shared cell instance.

Parameters:
- LEN_W, 4, width of per-transaction bit-count fields; max transaction length is 2^LEN_W-1 bits.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  request per requester; held high for the whole transaction.
- len0  in  LEN_W  bit count for requester 0; sampled at grant.
- len1  in  LEN_W  bit count for requester 1; sampled at grant.
- din0  in  1  serial data bit from requester 0.
- din1  in  1  serial data bit from requester 1.
- gnt  out  2  one-hot grant, registered.
- busy  out  1  high in any state other than IDLE.
- cell_S  out  1  drives cell S.
- cell_I  out  1  drives cell I.
- cell_T  out  1  drives cell T.
- cell_rst_n  out  1  active-low clear of the cell's flip-flops.
- cell_b1  in  1  cell output b1.
- cell_b2  in  1  cell output b2.
- rsp_valid  out  1  rsp_b1/rsp_b2 valid this cycle.
- rsp_b1  out  1  registered b1 of the bit sent last cycle.
- rsp_b2  out  1  registered b2 of the bit sent last cycle.
- done  out  2  one-cycle completion pulse per requester.
- aborted  out  1  qualifies done: transaction ended early.

Behaviour:
- Reset (reset=0, async): state=IDLE, gnt=0, busy=0, rsp_valid=0, rsp_b1=rsp_b2=0, done=0, aborted=0, cell_rst_n=0, rr pointer=0 (requester 0 preferred).
- States: IDLE, CLEAR, RUN, DONE.
- Cell control per state (outputs are combinational from registered state, except cell_I):
  - IDLE: cell_S=1, cell_I=0, cell_T=0, cell_rst_n=1.
  - CLEAR: cell_rst_n=0 for exactly one cycle; S/I/T as in IDLE.
  - RUN: cell_S=0, cell_T=1, cell_rst_n=1; cell_I = din of the granted requester (combinational through a gnt-selected mux).
  - DONE: as IDLE.
- IDLE → CLEAR when any req is high.
  - Winner: the single requester, or on a tie the one the rr pointer favours.
  - At that edge: gnt set, winner's len latched into remaining counter, rr pointer set to the loser.
- CLEAR → RUN if latched len≠0; CLEAR → DONE if len=0 (no RUN cycles, no rsp_valid).
- RUN:
  - Each cycle sends one bit and decrements remaining.
  - On the cycle remaining=1: → DONE.
  - Total RUN cycles = len.
- Response timing:
  - rsp_valid is high in the cycle after each RUN cycle.
  - rsp_b1/rsp_b2 = cell_b1/cell_b2 sampled at the end of that RUN cycle.
  - The last response therefore appears in the DONE cycle.
- DONE:
  - done[g]=1 for exactly one cycle; gnt cleared at exit.
  - DONE → IDLE unconditionally; no back-to-back grant without an IDLE cycle.
- Abort: if req[g] falls while in CLEAR or RUN, the next state is DONE with aborted=1 alongside done[g]. The rsp_valid for the final sent bit is still produced.
- Non-granted requester: its req changes are ignored until IDLE; its din is never routed.
- len0/len1 changes after grant: no effect.
- gnt is never two-hot; busy = (state≠IDLE).

Optional Feature:
- Macro: MEALY_SHARE_ARB_STATS_EN.
- With the macro defined:
  - Adds output ports cnt0 [7:0] and cnt1 [7:0].
  - Each counts completed non-aborted transactions of its requester, incrementing in the DONE cycle.
  - Counters saturate at 255 and are cleared by reset.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mealy_arb_pkg holds:
  - state encoding constants IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3;
  - default LEN_W=4;
  - stats counter width 8.
- One sub-module, rr_pick2:
  - inputs: req[1:0], ptr;
  - outputs: one-hot pick[1:0];
  - purely combinational;
  - instanced once for the IDLE decision.

Test Plan:
- Reset, then req=01, len0=3, din0 sequence 1,0,1 → gnt=01 one cycle after req; cell_rst_n low one cycle; 3 RUN cycles with cell_S=0, cell_T=1, cell_I=1,0,1; rsp_valid high for 3 cycles; done=01 on the third response cycle; aborted=0.
- req=11 from reset, len0=len1=2, both held through completion → requester 0 served first; one IDLE cycle; then requester 1 granted; gnt never 11.
- req=01, len0=0 → IDLE → CLEAR → DONE; done=01, no rsp_valid, busy high for exactly 2 cycles.
- req=10, len1=5, drop req[1] after the second RUN cycle → DONE next with done=10, aborted=1; exactly 2 rsp_valid pulses.
- Assert reset=0 mid-RUN (asynchronously, between clock edges) → gnt=0, busy=0, cell_rst_n=0, rsp_valid=0 immediately, without waiting for Clk.
- With MEALY_SHARE_ARB_STATS_EN: 3 completed requester-0 transactions plus 1 aborted → cnt0=3, cnt1=0; 260 completions → cnt0 holds 255.
